// File: rtl/pcs_an_ctrl.sv
// pcs_an_ctrl: 1000BASE-X auto-negotiation controller.
// Tracks the RUDI stream from the PCS receiver and sequences xmit and
// tx_Config_Reg through the negotiation handshake. The match flags are one
// register stage behind the tracker counters. Outputs are registered from
// next_state, so they are valid in the first cycle a state is occupied.
module pcs_an_ctrl #(
  parameter int LINK_TIMER = 1250000,
  parameter int TIMER_W    = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_status,
  input  logic        rudi_valid,
  input  logic [1:0]  rudi,
  input  logic [15:0] rx_Config_Reg,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic [15:0] mr_adv_ability,
  output logic [1:0]  xmit,
  output logic [15:0] tx_Config_Reg,
  output logic        mr_an_complete,
  output logic        mr_page_rx,
  output logic [15:0] mr_lp_adv_ability,
  output logic [2:0]  an_state
);

  typedef enum logic [2:0] {
    AN_ENABLE            = 3'd0,
    AN_RESTART           = 3'd1,
    ABILITY_DETECT       = 3'd2,
    ACKNOWLEDGE_DETECT   = 3'd3,
    COMPLETE_ACKNOWLEDGE = 3'd4,
    IDLE_DETECT          = 3'd5,
    LINK_OK              = 3'd6,
    AN_DISABLE_LINK_OK   = 3'd7
  } an_state_t;

  localparam logic [1:0]  RUDI_CONFIG = 2'd0;
  localparam logic [1:0]  RUDI_IDLE   = 2'd1;
  localparam logic [1:0]  XMIT_CONFIG = 2'd0;
  localparam logic [1:0]  XMIT_IDLE   = 2'd1;
  localparam logic [1:0]  XMIT_DATA   = 2'd2;
  // Bit 14 is the acknowledge bit; ability comparisons ignore it.
  localparam logic [15:0] ABIL_MASK   = 16'hBFFF;
  localparam logic [15:0] ACK_BIT     = 16'h4000;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LINK_TIMER - 1);

  an_state_t          r_state;
  an_state_t          w_next_state;
  logic               w_capture;

  logic [1:0]         r_cfg_cnt;
  logic [1:0]         r_idle_cnt;
  logic               r_ack_all;
  logic [15:0]        r_last_word;

  logic               r_ability_match;
  logic               r_ack_match;
  logic               r_idle_match;
  logic               r_zero_match;
  logic               w_consistency;

  logic [TIMER_W-1:0] r_timer;
  logic               w_timer_done;

  logic [1:0]         r_xmit;
  logic [15:0]        r_tx_cfg;
  logic               r_an_complete;
  logic               r_page_rx;
  logic [15:0]        r_lp_ability;

  // Match tracker: counts consecutive identical /C/ words and /I/ sets.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_cnt   <= 2'd0;
      r_idle_cnt  <= 2'd0;
      r_ack_all   <= 1'b0;
      r_last_word <= 16'h0000;
    end else if (rudi_valid) begin
      case (rudi)
        RUDI_CONFIG: begin
          if ((rx_Config_Reg & ABIL_MASK) == (r_last_word & ABIL_MASK)) begin
            r_cfg_cnt <= (r_cfg_cnt == 2'd3) ? 2'd3 : r_cfg_cnt + 2'd1;
            r_ack_all <= r_ack_all & rx_Config_Reg[14];
          end else begin
            r_cfg_cnt <= 2'd1;
            r_ack_all <= rx_Config_Reg[14];
          end
          r_last_word <= rx_Config_Reg;
          r_idle_cnt  <= 2'd0;
        end
        RUDI_IDLE: begin
          r_idle_cnt <= (r_idle_cnt == 2'd3) ? 2'd3 : r_idle_cnt + 2'd1;
          r_cfg_cnt  <= 2'd0;
        end
        default: begin
          r_cfg_cnt  <= 2'd0;
          r_idle_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Registered match flags, one cycle behind the tracker counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ability_match <= 1'b0;
      r_ack_match     <= 1'b0;
      r_idle_match    <= 1'b0;
      r_zero_match    <= 1'b0;
    end else begin
      r_ability_match <= (r_cfg_cnt == 2'd3);
      r_ack_match     <= (r_cfg_cnt == 2'd3) && r_ack_all;
      r_idle_match    <= (r_idle_cnt == 2'd3);
      r_zero_match    <= (r_cfg_cnt == 2'd3) && ((r_last_word & ABIL_MASK) == 16'h0000);
    end
  end

  assign w_consistency = (r_last_word & ABIL_MASK) == (mr_lp_adv_ability & ABIL_MASK);
  assign w_timer_done  = (r_timer >= TIMER_LAST);

  // link_timer: restarts on every state change, saturates at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_next_state != r_state) begin
      r_timer <= '0;
    end else if (r_timer != {TIMER_W{1'b1}}) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= AN_ENABLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; restart / loss of sync override every transition.
  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    if (mr_restart_an || (!sync_status && mr_an_enable)) begin
      w_next_state = AN_ENABLE;
    end else begin
      case (r_state)
        AN_ENABLE:
          w_next_state = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
        AN_RESTART:
          if (w_timer_done) w_next_state = ABILITY_DETECT;
        ABILITY_DETECT:
          if (r_ability_match && !r_zero_match) begin
            w_next_state = ACKNOWLEDGE_DETECT;
            w_capture    = 1'b1;
          end
        ACKNOWLEDGE_DETECT:
          if (r_zero_match || (r_ack_match && !w_consistency))
            w_next_state = AN_ENABLE;
          else if (r_ack_match && w_consistency)
            w_next_state = COMPLETE_ACKNOWLEDGE;
        COMPLETE_ACKNOWLEDGE:
          if (r_zero_match)      w_next_state = AN_ENABLE;
          else if (w_timer_done) w_next_state = IDLE_DETECT;
        IDLE_DETECT:
          if (r_zero_match)                       w_next_state = AN_ENABLE;
          else if (w_timer_done && r_idle_match)  w_next_state = LINK_OK;
        LINK_OK:
          if (r_ability_match) w_next_state = AN_ENABLE;
        AN_DISABLE_LINK_OK:
          if (mr_an_enable) w_next_state = AN_ENABLE;
      endcase
    end
  end

  // Output registers: set on entry to / while in the next state, otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xmit        <= XMIT_CONFIG;
      r_tx_cfg      <= 16'h0000;
      r_an_complete <= 1'b0;
      r_page_rx     <= 1'b0;
      r_lp_ability  <= 16'h0000;
    end else begin
      case (w_next_state)
        AN_ENABLE: begin
          r_xmit        <= XMIT_CONFIG;
          r_tx_cfg      <= 16'h0000;
          r_an_complete <= 1'b0;
          r_page_rx     <= 1'b0;
        end
        AN_RESTART: begin
          r_xmit   <= XMIT_CONFIG;
          r_tx_cfg <= 16'h0000;
        end
        ABILITY_DETECT:       r_tx_cfg  <= mr_adv_ability & ABIL_MASK;
        ACKNOWLEDGE_DETECT:   r_tx_cfg  <= r_tx_cfg | ACK_BIT;
        COMPLETE_ACKNOWLEDGE: r_page_rx <= 1'b1;
        IDLE_DETECT:          r_xmit    <= XMIT_IDLE;
        LINK_OK: begin
          r_xmit        <= XMIT_DATA;
          r_an_complete <= 1'b1;
        end
        AN_DISABLE_LINK_OK:   r_xmit    <= XMIT_DATA;
      endcase
      if (w_capture) r_lp_ability <= r_last_word;
    end
  end

  assign xmit              = r_xmit;
  assign tx_Config_Reg     = r_tx_cfg;
  assign mr_an_complete    = r_an_complete;
  assign mr_page_rx        = r_page_rx;
  assign mr_lp_adv_ability = r_lp_ability;
  assign an_state          = r_state;

endmodule

// File: tb/tb_pcs_an_ctrl.sv
// tb_pcs_an_ctrl: directed handshake scenarios with literal expectations,
// followed by randomized RUDI / management stimulus. A behavioural model
// (ordered-set history + state rules) is compared against the DUT every cycle.
module tb_pcs_an_ctrl;

  localparam int LT = 16;
  localparam int TW = 5;

  localparam logic [1:0] RC = 2'd0;  // /C/
  localparam logic [1:0] RI = 2'd1;  // /I/
  localparam logic [1:0] RV = 2'd2;  // INVALID

  localparam int S_EN = 0, S_RST = 1, S_ABIL = 2, S_ACK = 3,
                 S_CACK = 4, S_IDLE = 5, S_LINK = 6, S_DIS = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync_status;
  logic        rudi_valid;
  logic [1:0]  rudi;
  logic [15:0] rx_Config_Reg;
  logic        mr_an_enable;
  logic        mr_restart_an;
  logic [15:0] mr_adv_ability;
  logic [1:0]  xmit;
  logic [15:0] tx_Config_Reg;
  logic        mr_an_complete;
  logic        mr_page_rx;
  logic [15:0] mr_lp_adv_ability;
  logic [2:0]  an_state;

  always #5 clk = ~clk;

  pcs_an_ctrl #(.LINK_TIMER(LT), .TIMER_W(TW)) dut (
    .clk               (clk),
    .reset             (reset),
    .sync_status       (sync_status),
    .rudi_valid        (rudi_valid),
    .rudi              (rudi),
    .rx_Config_Reg     (rx_Config_Reg),
    .mr_an_enable      (mr_an_enable),
    .mr_restart_an     (mr_restart_an),
    .mr_adv_ability    (mr_adv_ability),
    .xmit              (xmit),
    .tx_Config_Reg     (tx_Config_Reg),
    .mr_an_complete    (mr_an_complete),
    .mr_page_rx        (mr_page_rx),
    .mr_lp_adv_ability (mr_lp_adv_ability),
    .an_state          (an_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          ev_kind[$];    // every ordered-set result seen since reset
  logic [15:0] cfg_words[$];  // /C/ words, led by the all-zero word held at reset
  int          m_state;
  int          m_dwell;       // cycles spent in the current state
  logic [1:0]  m_xmit;
  logic [15:0] m_tx;
  logic [15:0] m_lp;
  logic        m_complete;
  logic        m_page;
  bit          m_ab, m_ak, m_id, m_zr;  // flags as seen by the state machine
  bit          started = 1'b0;

  function automatic logic [15:0] msk(input logic [15:0] w);
    return w & 16'hBFFF;
  endfunction

  // Flags from the history: three latest results all /C/ with one ability,
  // acknowledge set across the whole run of that ability, or three /I/.
  function automatic void raw_flags(output bit ab, output bit ak, output bit idl, output bit zr);
    int n;
    int c;
    bit all;
    n = ev_kind.size();
    c = cfg_words.size();
    ab = 1'b0; ak = 1'b0; idl = 1'b0; zr = 1'b0;
    if (n >= 3) begin
      if (ev_kind[n-1] == 0 && ev_kind[n-2] == 0 && ev_kind[n-3] == 0 &&
          msk(cfg_words[c-1]) == msk(cfg_words[c-2]) &&
          msk(cfg_words[c-2]) == msk(cfg_words[c-3]))
        ab = 1'b1;
      if (ev_kind[n-1] == 1 && ev_kind[n-2] == 1 && ev_kind[n-3] == 1)
        idl = 1'b1;
    end
    if (ab) begin
      all = 1'b1;
      for (int k = c - 1; k >= 0; k--) begin
        all &= cfg_words[k][14];
        if (k == 0 || msk(cfg_words[k]) != msk(cfg_words[k-1])) break;
      end
      ak = all;
      zr = (msk(cfg_words[c-1]) == 16'h0000);
    end
  endfunction

  always @(posedge clk) begin
    bit nab, nak, nid, nzr, cons, tdone;
    int nxt;
    logic [15:0] last;
    started = 1'b1;
    if (reset) begin
      ev_kind.delete();
      cfg_words.delete();
      cfg_words.push_back(16'h0000);
      m_state = S_EN; m_dwell = 0;
      m_xmit = 2'd0; m_tx = 16'h0000; m_lp = 16'h0000;
      m_complete = 1'b0; m_page = 1'b0;
      m_ab = 1'b0; m_ak = 1'b0; m_id = 1'b0; m_zr = 1'b0;
    end else begin
      raw_flags(nab, nak, nid, nzr);
      last  = cfg_words[cfg_words.size()-1];
      cons  = (msk(last) == msk(m_lp));
      tdone = (m_dwell >= LT - 1);
      nxt   = m_state;
      if (mr_restart_an || (!sync_status && mr_an_enable)) nxt = S_EN;
      else begin
        case (m_state)
          S_EN:   nxt = mr_an_enable ? S_RST : S_DIS;
          S_RST:  if (tdone) nxt = S_ABIL;
          S_ABIL: if (m_ab && !m_zr) begin nxt = S_ACK; m_lp = last; end
          S_ACK:  if (m_zr || (m_ak && !cons)) nxt = S_EN;
                  else if (m_ak) nxt = S_CACK;
          S_CACK: if (m_zr) nxt = S_EN; else if (tdone) nxt = S_IDLE;
          S_IDLE: if (m_zr) nxt = S_EN; else if (tdone && m_id) nxt = S_LINK;
          S_LINK: if (m_ab) nxt = S_EN;
          default: if (mr_an_enable) nxt = S_EN;
        endcase
      end
      case (nxt)
        S_EN:   begin m_xmit = 2'd0; m_tx = 16'h0000; m_complete = 1'b0; m_page = 1'b0; end
        S_RST:  begin m_xmit = 2'd0; m_tx = 16'h0000; end
        S_ABIL: m_tx = msk(mr_adv_ability);
        S_ACK:  m_tx = m_tx | 16'h4000;
        S_CACK: m_page = 1'b1;
        S_IDLE: m_xmit = 2'd1;
        S_LINK: begin m_xmit = 2'd2; m_complete = 1'b1; end
        default: m_xmit = 2'd2;
      endcase
      m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
      m_state = nxt;
      if (rudi_valid) begin
        ev_kind.push_back(int'(rudi));
        if (rudi == RC) cfg_words.push_back(rx_Config_Reg);
      end
      m_ab = nab; m_ak = nak; m_id = nid; m_zr = nzr;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (started) begin
      check("state",    32'(an_state),          32'(m_state));
      check("xmit",     32'(xmit),              32'(m_xmit));
      check("tx_cfg",   32'(tx_Config_Reg),     32'(m_tx));
      check("complete", 32'(mr_an_complete),    32'(m_complete));
      check("page_rx",  32'(mr_page_rx),        32'(m_page));
      check("lp_abil",  32'(mr_lp_adv_ability), 32'(m_lp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] kind, input logic [15:0] w);
    rudi_valid    = 1'b1;
    rudi          = kind;
    rx_Config_Reg = w;
    @(negedge clk);
    rudi_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send3(input logic [1:0] kind, input logic [15:0] w);
    repeat (3) send(kind, w);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget && int'(an_state) != s; i++) @(negedge clk);
    check(name, 32'(an_state), 32'(s));
  endtask

  // Drives a partner through the handshake up to IDLE_DETECT. The ability
  // comparison ignores bit 14, so the partner announces one distinct word
  // before the acknowledged run to start a fresh acknowledge run.
  task automatic to_idle_detect(input logic [15:0] w);
    wait_state(S_ABIL, LT + 8, "hs_ability");
    send3(RC, w);
    wait_state(S_ACK, 6, "hs_ack");
    send(RC, w ^ 16'h4001);
    send3(RC, w | 16'h4000);
    wait_state(S_CACK, 6, "hs_cack");
    wait_state(S_IDLE, LT + 4, "hs_idle");
  endtask

  logic [15:0] words [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int len;
    logic [15:0] w;
    words = '{16'h0020, 16'h4020, 16'h0000, 16'h4000, 16'h0040, 16'h4040};
    reset = 1'b1; sync_status = 1'b1; mr_an_enable = 1'b0; mr_restart_an = 1'b0;
    mr_adv_ability = 16'h01A0; rudi_valid = 1'b0; rudi = RC; rx_Config_Reg = 16'h0000;
    tick(3);
    check("rst_state", 32'(an_state), 32'(S_EN));
    check("rst_xmit",  32'(xmit), 32'd0);
    check("rst_tx",    32'(tx_Config_Reg), 32'h0);
    check("rst_lp",    32'(mr_lp_adv_ability), 32'h0);

    // AN disabled: DISABLE_LINK_OK on the second cycle after reset.
    reset = 1'b0;
    tick(1);
    check("dis_state", 32'(an_state), 32'(S_DIS));
    check("dis_xmit",  32'(xmit), 32'd2);
    tick(5);
    check("dis_complete", 32'(mr_an_complete), 32'd0);

    // Full handshake with adv=0x01A0; restart dwell is exactly LT cycles.
    mr_an_enable = 1'b1;
    tick(1);
    check("en_state", 32'(an_state), 32'(S_EN));
    tick(1);
    check("restart_state", 32'(an_state), 32'(S_RST));
    tick(LT - 1);
    check("restart_dwell", 32'(an_state), 32'(S_RST));
    tick(1);
    check("abil_state", 32'(an_state), 32'(S_ABIL));
    check("abil_tx", 32'(tx_Config_Reg), 32'h01A0);
    send3(RC, 16'h0020);
    wait_state(S_ACK, 4, "ack_entry");
    check("ack_tx", 32'(tx_Config_Reg), 32'h41A0);
    check("ack_lp", 32'(mr_lp_adv_ability), 32'h0020);
    send(RC, 16'h4021);
    send3(RC, 16'h4020);
    wait_state(S_CACK, 4, "cack_entry");
    check("cack_page", 32'(mr_page_rx), 32'd1);
    check("cack_lp", 32'(mr_lp_adv_ability), 32'h0020);
    wait_state(S_IDLE, LT + 2, "idle_entry");
    check("idle_xmit", 32'(xmit), 32'd1);
    send3(RI, 16'h0000);
    wait_state(S_LINK, LT + 2, "link_entry");
    check("link_xmit", 32'(xmit), 32'd2);
    check("link_complete", 32'(mr_an_complete), 32'd1);

    // Loss of sync in LINK_OK.
    sync_status = 1'b0;
    tick(1);
    check("sync_state", 32'(an_state), 32'(S_EN));
    check("sync_xmit", 32'(xmit), 32'd0);
    check("sync_complete", 32'(mr_an_complete), 32'd0);
    sync_status = 1'b1;
    tick(1);
    check("sync_restart", 32'(an_state), 32'(S_RST));

    // Inconsistent acknowledgement aborts to AN_ENABLE.
    wait_state(S_ABIL, LT + 4, "inc_ability");
    send3(RC, 16'h0020);
    wait_state(S_ACK, 4, "inc_ack");
    check("inc_lp", 32'(mr_lp_adv_ability), 32'h0020);
    send3(RC, 16'h4040);
    wait_state(S_EN, 6, "inc_abort");
    check("inc_tx", 32'(tx_Config_Reg), 32'h0);
    check("inc_xmit", 32'(xmit), 32'd0);
    send(RV, 16'h0000);  // clear the stale ability run during restart

    // Match filtering.
    wait_state(S_ABIL, LT + 4, "flt_ability");
    send(RC, 16'h0020); send(RC, 16'h0021); send(RC, 16'h0020); send(RC, 16'h0020);
    tick(4);
    check("flt_nomatch", 32'(an_state), 32'(S_ABIL));
    send(RC, 16'h0030); send(RC, 16'h0030); send(RV, 16'h0030);
    send(RC, 16'h0030); send(RC, 16'h0030);
    tick(4);
    check("flt_invalid", 32'(an_state), 32'(S_ABIL));
    send(RC, 16'h0030);
    wait_state(S_ACK, 4, "flt_fresh");
    check("flt_lp", 32'(mr_lp_adv_ability), 32'h0030);

    // Reset mid-negotiation.
    reset = 1'b1;
    tick(1);
    check("midrst_state", 32'(an_state), 32'(S_EN));
    check("midrst_lp", 32'(mr_lp_adv_ability), 32'h0);
    reset = 1'b0;

    // Partner restart from LINK_OK with all-zero words.
    to_idle_detect(16'h0020);
    send3(RI, 16'h0000);
    wait_state(S_LINK, LT + 2, "pr_link");
    send3(RC, 16'h0000);
    wait_state(S_EN, 4, "pr_restart");
    check("pr_complete", 32'(mr_an_complete), 32'd0);

    // Management restart pulse in IDLE_DETECT; AN_ENABLE held while high.
    to_idle_detect(16'h0020);
    mr_restart_an = 1'b1;
    tick(1);
    check("mr_restart", 32'(an_state), 32'(S_EN));
    tick(2);
    check("mr_hold", 32'(an_state), 32'(S_EN));
    mr_restart_an = 1'b0;
    tick(1);
    check("mr_release", 32'(an_state), 32'(S_RST));

    // Randomized partner and management behaviour.
    for (int seg = 0; seg < 120; seg++) begin
      mode = int'($urandom_range(0, 4));
      len  = int'($urandom_range(10, 60));
      w    = words[$urandom_range(0, 5)];
      for (int i = 0; i < len; i++) begin
        rudi_valid = 1'b0;
        case (mode)
          0: begin rudi_valid = ($urandom_range(0, 1) == 1); rudi = RC; rx_Config_Reg = w; end
          1: begin rudi_valid = ($urandom_range(0, 1) == 1); rudi = RC; rx_Config_Reg = w | 16'h4000; end
          2: begin rudi_valid = ($urandom_range(0, 1) == 1); rudi = RI; end
          3: begin
            rudi_valid    = ($urandom_range(0, 1) == 1);
            rudi          = 2'($urandom_range(0, 2));
            rx_Config_Reg = words[$urandom_range(0, 5)];
          end
          default: ;
        endcase
        reset         = ($urandom_range(0, 799) == 0);
        mr_restart_an = ($urandom_range(0, 199) == 0);
        sync_status   = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 999) == 0) mr_an_enable = ~mr_an_enable;
        if ($urandom_range(0, 499) == 0) mr_adv_ability = words[$urandom_range(0, 5)] | 16'h0180;
        @(negedge clk);
      end
    end

    reset = 1'b0; rudi_valid = 1'b0; mr_restart_an = 1'b0; sync_status = 1'b1;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
